// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline-stage register: ID/EX payload
// layout, stage occupancy states and the flush kill-count helper.
package pipe_pkg;

    // Width of the ID/EX payload.
    localparam int ID_EX_DW = 120;

    // ID/EX payload, MSB first.
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  ctl;
        logic [3:0]  msg;
        logic [31:0] rs2_v;
        logic [31:0] rs1_v;
        logic [4:0]  rd;
        logic [4:0]  rs2;
        logic [4:0]  rs1;
    } idex_payload_t;

    // Stage occupancy: nothing held, output register live, output + skid live.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_t;

    // Number of live entries a flush throws away. An output entry the
    // consumer is taking in the same cycle is a transfer, not a kill.
    function automatic logic [1:0] killed_entries(input logic flush,
                                                  input logic out_valid,
                                                  input logic out_ready,
                                                  input logic skid_valid);
        logic [1:0] n;
        n = 2'd0;
        if (flush) begin
            n = {1'b0, out_valid & ~out_ready} + {1'b0, skid_valid};
        end else begin
            n = 2'd0;
        end
        return n;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data handshake bundle used on both sides of a pipeline stage.
interface pipe_stage_reg_if #(
    parameter int DW = 120
) ();
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    // Producer side: drives valid/data, observes ready.
    modport master (output valid, output data, input ready);
    // Consumer side: observes valid/data, drives ready.
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg_skid.sv
// One-entry skid register with its valid bit. Catches a payload accepted
// while the output register is stalled so in_ready can be a pure register.
module pipe_skid_buf #(
    parameter int DW = 120
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    // Skid entry: clear wins over load; payload holds when cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= {DW{1'b0}};
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready handshake, stall,
// synchronous flush and a saturating count of flushed instructions.
// Build option PIPE_SKID_EN: adds a one-entry skid buffer so in_ready is
// a register output (no out_ready -> in_ready combinational path).
// Without it in_ready = out_ready | !out_valid.
// CNTW must be at least 2.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int            DW      = ID_EX_DW,
    parameter logic [DW-1:0] RST_VAL = {DW{1'b0}},
    parameter int            CNTW    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    pipe_stage_reg_if.slave   in_if,
    pipe_stage_reg_if.master  out_if,
    output logic [CNTW-1:0]   kill_cnt
);

    stage_state_t    state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [CNTW-1:0] kill_cnt_q, kill_cnt_d;

    logic            in_ready_s;
    logic            accept_s;
    logic            xfer_s;
    logic            skid_valid_s;
    logic [DW-1:0]   skid_data_s;
    logic [1:0]      killed_s;
    logic [CNTW:0]   kill_sum_s;

    assign accept_s = in_if.valid & in_ready_s & ~flush;
    assign xfer_s   = out_valid_q & out_if.ready;

`ifdef PIPE_SKID_EN
    logic skid_load_s;
    logic skid_clear_s;

    // Skid control: fill when accepting while stalled, drain on transfer, drop on flush.
    always_comb begin
        skid_load_s  = 1'b0;
        skid_clear_s = 1'b0;
        if (flush) begin
            skid_clear_s = 1'b1;
        end else if ((state_q == ST_FULL) && accept_s && !xfer_s) begin
            skid_load_s = 1'b1;
        end else if ((state_q == ST_SKID) && xfer_s) begin
            skid_clear_s = 1'b1;
        end else begin
            skid_load_s  = 1'b0;
            skid_clear_s = 1'b0;
        end
    end

    pipe_skid_buf #(.DW(DW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clear_i (skid_clear_s),
        .load_i  (skid_load_s),
        .data_i  (in_if.data),
        .valid_o (skid_valid_s),
        .data_o  (skid_data_s)
    );

    // A free skid slot guarantees room, so readiness is purely registered.
    assign in_ready_s = ~skid_valid_s;
`else
    assign skid_valid_s = 1'b0;
    assign skid_data_s  = {DW{1'b0}};

    // Room exists when the stage is empty or its entry leaves this cycle.
    assign in_ready_s = out_if.ready | ~out_valid_q;
`endif

    // State, output and kill-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            out_data_q  <= RST_VAL;
            kill_cnt_q  <= {CNTW{1'b0}};
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    // Next-state: flush empties the stage, otherwise follow accepts and transfers.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) state_d = ST_FULL;
                    else          state_d = ST_EMPTY;
                end
                ST_FULL: begin
                    if (accept_s && !xfer_s)      state_d = ST_SKID;
                    else if (xfer_s && !accept_s) state_d = ST_EMPTY;
                    else                          state_d = ST_FULL;
                end
                ST_SKID: begin
                    if (xfer_s) state_d = ST_FULL;
                    else        state_d = ST_SKID;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Output register: load new payload, pull from skid, or hold (also on flush).
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = (state_d != ST_EMPTY);
        if (flush) begin
            out_data_d = out_data_q;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) out_data_d = in_if.data;
                    else          out_data_d = out_data_q;
                end
                ST_FULL: begin
                    if (accept_s && xfer_s) out_data_d = in_if.data;
                    else                    out_data_d = out_data_q;
                end
                ST_SKID: begin
                    if (xfer_s) out_data_d = skid_data_s;
                    else        out_data_d = out_data_q;
                end
                default: out_data_d = out_data_q;
            endcase
        end
    end

    // Kill counter: add discarded live entries, saturating at all-ones.
    always_comb begin
        killed_s   = killed_entries(flush, out_valid_q, out_if.ready, skid_valid_s);
        kill_sum_s = {1'b0, kill_cnt_q} + {{(CNTW-1){1'b0}}, killed_s};
        if (kill_sum_s[CNTW]) begin
            kill_cnt_d = {CNTW{1'b1}};
        end else begin
            kill_cnt_d = kill_sum_s[CNTW-1:0];
        end
    end

    assign in_if.ready  = in_ready_s;
    assign out_if.valid = out_valid_q;
    assign out_if.data  = out_data_q;
    assign kill_cnt     = kill_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: payloads expected at the output are
// queued as they are issued, a negedge monitor pops them on every transfer.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic clk;
    logic rst;
    logic flush;
    logic [15:0] kill_cnt;
    logic flush2;
    logic [1:0] kill2;

    pipe_stage_reg_if #(.DW(120)) in_if ();
    pipe_stage_reg_if #(.DW(120)) out_if ();
    pipe_stage_reg_if #(.DW(120)) s_in_if ();
    pipe_stage_reg_if #(.DW(120)) s_out_if ();

    pipe_stage_reg #(.DW(120), .RST_VAL(120'd0), .CNTW(16)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_if    (in_if),
        .out_if   (out_if),
        .kill_cnt (kill_cnt)
    );

    // Narrow counter instance to reach saturation quickly.
    pipe_stage_reg #(.DW(120), .RST_VAL(120'd0), .CNTW(2)) u_sat (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush2),
        .in_if    (s_in_if),
        .out_if   (s_out_if),
        .kill_cnt (kill2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [119:0] sb_q[$];
    logic [15:0]  exp_kill;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [119:0] act, input logic [119:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer must match the oldest queued payload.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_if.valid === 1'b1 && out_if.ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_extra: got 0x%0h, expected no transfer", out_if.data);
            end else begin
                chk("sb_data", out_if.data, sb_q.pop_front());
            end
        end
    end

    // Drive one cycle of inputs, check outputs at the negedge, advance.
    task automatic step(input logic v, input logic [119:0] d, input logic r, input logic f,
                        input logic e_ov, input logic [119:0] e_od,
                        input logic e_ir_ns, input logic e_ir_sk, input string tag);
        logic e_ir;
`ifdef PIPE_SKID_EN
        e_ir = e_ir_sk;
`else
        e_ir = e_ir_ns;
`endif
        in_if.valid  = v;
        in_if.data   = d;
        out_if.ready = r;
        flush        = f;
        @(negedge clk);
        chk({tag, "_out_valid"}, {119'd0, out_if.valid}, {119'd0, e_ov});
        chk({tag, "_out_data"}, out_if.data, e_od);
        chk({tag, "_in_ready"}, {119'd0, in_if.ready}, {119'd0, e_ir});
        chk({tag, "_kill_cnt"}, {104'd0, kill_cnt}, {104'd0, exp_kill});
        @(posedge clk);
        #1;
    endtask

    // Cycle of the saturation instance: checks its counter and valid.
    task automatic sat_step(input logic v, input logic f, input logic e_ov,
                            input logic [1:0] e_k, input string tag);
        s_in_if.valid  = v;
        s_in_if.data   = 120'h5A;
        s_out_if.ready = 1'b0;
        flush2         = f;
        @(negedge clk);
        chk({tag, "_valid"}, {119'd0, s_out_if.valid}, {119'd0, e_ov});
        chk({tag, "_kill"}, {118'd0, kill2}, {118'd0, e_k});
        @(posedge clk);
        #1;
    endtask

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] exp_sat;
        exp_kill       = 16'd0;
        // 1: reset with a pending input
        rst            = 1'b0;
        flush          = 1'b0;
        in_if.valid    = 1'b1;
        in_if.data     = 120'hABC;
        out_if.ready   = 1'b0;
        flush2         = 1'b0;
        s_in_if.valid  = 1'b0;
        s_in_if.data   = 120'd0;
        s_out_if.ready = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {119'd0, out_if.valid}, 120'd0);
        chk("rst_out_data", out_if.data, 120'd0);
        chk("rst_kill_cnt", {104'd0, kill_cnt}, 120'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, 120'd0, 1'b0, 1'b0, 1'b0, 120'd0, 1'b1, 1'b1, "rst_rel");

        // 2: streaming 1,2,3 with the consumer always ready
        sb_q.push_back(120'd1);
        step(1'b1, 120'd1, 1'b1, 1'b0, 1'b0, 120'd0, 1'b1, 1'b1, "str0");
        sb_q.push_back(120'd2);
        step(1'b1, 120'd2, 1'b1, 1'b0, 1'b1, 120'd1, 1'b1, 1'b1, "str1");
        sb_q.push_back(120'd3);
        step(1'b1, 120'd3, 1'b1, 1'b0, 1'b1, 120'd2, 1'b1, 1'b1, "str2");
        step(1'b0, 120'd0, 1'b1, 1'b0, 1'b1, 120'd3, 1'b1, 1'b1, "str3");
        step(1'b0, 120'd0, 1'b1, 1'b0, 1'b0, 120'd3, 1'b1, 1'b1, "bubble");

        // 3: stall with 0x55 held and 0x66 waiting
        sb_q.push_back(120'h55);
        step(1'b1, 120'h55, 1'b0, 1'b0, 1'b0, 120'd3, 1'b1, 1'b1, "stl0");
`ifdef PIPE_SKID_EN
        sb_q.push_back(120'h66);
`endif
        step(1'b1, 120'h66, 1'b0, 1'b0, 1'b1, 120'h55, 1'b0, 1'b1, "stl1");
        step(1'b1, 120'h66, 1'b0, 1'b0, 1'b1, 120'h55, 1'b0, 1'b0, "stl2");
        step(1'b1, 120'h66, 1'b0, 1'b0, 1'b1, 120'h55, 1'b0, 1'b0, "stl3");
        step(1'b1, 120'h66, 1'b0, 1'b0, 1'b1, 120'h55, 1'b0, 1'b0, "stl4");
`ifndef PIPE_SKID_EN
        sb_q.push_back(120'h66);
`endif
        step(1'b1, 120'h66, 1'b1, 1'b0, 1'b1, 120'h55, 1'b1, 1'b0, "rel0");
        step(1'b0, 120'd0, 1'b1, 1'b0, 1'b1, 120'h66, 1'b1, 1'b1, "rel1");
        step(1'b0, 120'd0, 1'b1, 1'b0, 1'b0, 120'h66, 1'b1, 1'b1, "rel2");

        // 4: flush with the stage full (and skid full when built), consumer stalled
        step(1'b1, 120'h11, 1'b0, 1'b0, 1'b0, 120'h66, 1'b1, 1'b1, "fl0");
        step(1'b1, 120'h22, 1'b0, 1'b0, 1'b1, 120'h11, 1'b0, 1'b1, "fl1");
        step(1'b1, 120'h77, 1'b0, 1'b1, 1'b1, 120'h11, 1'b0, 1'b0, "fl2");
`ifdef PIPE_SKID_EN
        exp_kill = 16'd2;
`else
        exp_kill = 16'd1;
`endif
        step(1'b0, 120'd0, 1'b0, 1'b0, 1'b0, 120'h11, 1'b1, 1'b1, "fl3");
        step(1'b0, 120'd0, 1'b1, 1'b0, 1'b0, 120'h11, 1'b1, 1'b1, "fl4");

        // 5: flush while the consumer takes the only entry: not a kill
        sb_q.push_back(120'h33);
        step(1'b1, 120'h33, 1'b0, 1'b0, 1'b0, 120'h11, 1'b1, 1'b1, "ft0");
        step(1'b0, 120'd0, 1'b1, 1'b1, 1'b1, 120'h33, 1'b1, 1'b1, "ft1");
        step(1'b0, 120'd0, 1'b1, 1'b0, 1'b0, 120'h33, 1'b1, 1'b1, "ft2");

        // 5b: saturation on the 2-bit counter instance
        exp_sat = 2'd0;
        for (int i = 0; i < 5; i++) begin
            sat_step(1'b1, 1'b0, 1'b0, exp_sat, "sat_ld");
            sat_step(1'b0, 1'b1, 1'b1, exp_sat, "sat_fl");
            exp_sat = (exp_sat == 2'd3) ? 2'd3 : exp_sat + 2'd1;
        end
        sat_step(1'b0, 1'b0, 1'b0, exp_sat, "sat_end");

        // 6: async reset while stalled (skid occupied when built)
        step(1'b1, 120'h44, 1'b0, 1'b0, 1'b0, 120'h33, 1'b1, 1'b1, "ar0");
        step(1'b1, 120'h45, 1'b0, 1'b0, 1'b1, 120'h44, 1'b0, 1'b1, "ar1");
        step(1'b0, 120'd0, 1'b0, 1'b0, 1'b1, 120'h44, 1'b0, 1'b0, "ar2");
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", {119'd0, out_if.valid}, 120'd0);
        chk("arst_out_data", out_if.data, 120'd0);
        chk("arst_kill_cnt", {104'd0, kill_cnt}, 120'd0);
        chk("arst_in_ready", {119'd0, in_if.ready}, 120'd1);
        exp_kill = 16'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, 120'd0, 1'b1, 1'b0, 1'b0, 120'd0, 1'b1, 1'b1, "post0");
        step(1'b0, 120'd0, 1'b1, 1'b0, 1'b0, 120'd0, 1'b1, 1'b1, "post1");
        sb_q.push_back(120'h99);
        step(1'b1, 120'h99, 1'b1, 1'b0, 1'b0, 120'd0, 1'b1, 1'b1, "post2");
        step(1'b0, 120'd0, 1'b1, 1'b0, 1'b1, 120'h99, 1'b1, 1'b1, "post3");
        step(1'b0, 120'd0, 1'b1, 1'b0, 1'b0, 120'h99, 1'b1, 1'b1, "post4");

        chk("sb_drained", {88'd0, 32'(sb_q.size())}, 120'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
